// File: rtl/cordic_pipe.sv
// cordic_pipe: fully pipelined signed CORDIC engine with quadrant pre-rotation and per-sample mode
//   clk                 rising-edge clock
//   rst                 asynchronous active-high reset, clears every stage and the outputs
//   in_valid, in_ready  input handshake; in_ready = adv = !out_valid || out_ready
//   in_mode             0 = rotation (drive z to 0), 1 = vectoring (drive y to 0)
//   x_in, y_in          signed WIDTH-bit vector
//   z_in                signed angle, binary angle measure (2^ZWIDTH = 2*pi)
//   out_valid,out_ready output handshake; every stage holds while out_valid && !out_ready
//   out_mode            mode of the sample at the output
//   x_out, y_out        signed WIDTH+2-bit results carrying the uncompensated CORDIC gain
//   z_out               residual (rotation) or accumulated (vectoring) angle
// ZWIDTH is limited to 32 because the arctangent table is held at 32-bit precision.
module cordic_pipe #(
    parameter int WIDTH  = 16,
    parameter int ZWIDTH = 32,
    parameter int STAGES = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mode,
    input  logic [WIDTH-1:0]  x_in,
    input  logic [WIDTH-1:0]  y_in,
    input  logic [ZWIDTH-1:0] z_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_mode,
    output logic [WIDTH+1:0]  x_out,
    output logic [WIDTH+1:0]  y_out,
    output logic [ZWIDTH-1:0] z_out
);
    localparam int XW = WIDTH + 2;

    // round(atan(2^-i) / (2*pi) * 2^32)
    localparam logic [31:0] ATAN [32] = '{
        32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
        32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
        32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
        32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
        32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
        32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
        32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
        32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000
    };

    // index 0 holds the pre-rotated sample, index k the result of micro-rotation k-1
    logic signed [XW-1:0]     xs [STAGES+1];
    logic signed [XW-1:0]     ys [STAGES+1];
    logic signed [ZWIDTH-1:0] zs [STAGES+1];
    logic                     ms [STAGES+1];
    logic                     vs [STAGES+1];

    logic signed [XW-1:0]     xn [STAGES];
    logic signed [XW-1:0]     yn [STAGES];
    logic signed [ZWIDTH-1:0] zn [STAGES];

    logic                     adv;
    logic                     flip;
    logic signed [XW-1:0]     x_ext;
    logic signed [XW-1:0]     y_ext;
    logic signed [XW-1:0]     x_pre;
    logic signed [XW-1:0]     y_pre;
    logic signed [ZWIDTH-1:0] z_pre;

    assign adv      = !vs[STAGES] || out_ready;
    assign in_ready = adv;

    // Rotating by 180 degrees brings every angle into the +/-90 degree range the
    // micro-rotations can reach; adding half a turn is a flip of the angle MSB.
    always_comb begin
        x_ext = XW'($signed(x_in));
        y_ext = XW'($signed(y_in));
        flip  = in_mode ? x_ext[XW-1] : (z_in[ZWIDTH-1] ^ z_in[ZWIDTH-2]);
        x_pre = flip ? -x_ext : x_ext;
        y_pre = flip ? -y_ext : y_ext;
        z_pre = $signed({z_in[ZWIDTH-1] ^ flip, z_in[ZWIDTH-2:0]});
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        localparam logic signed [ZWIDTH-1:0] ATAN_I = ZWIDTH'(ATAN[i] >> (32 - ZWIDTH));
        logic up;
        // up = (d == +1): rotation steers z toward 0, vectoring steers y toward 0
        assign up    = ms[i] ? ys[i][XW-1] : !zs[i][ZWIDTH-1];
        assign xn[i] = up ? xs[i] - (ys[i] >>> i) : xs[i] + (ys[i] >>> i);
        assign yn[i] = up ? ys[i] + (xs[i] >>> i) : ys[i] - (xs[i] >>> i);
        assign zn[i] = up ? zs[i] - ATAN_I : zs[i] + ATAN_I;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= STAGES; k++) begin
                xs[k] <= '0;
                ys[k] <= '0;
                zs[k] <= '0;
                ms[k] <= 1'b0;
                vs[k] <= 1'b0;
            end
        end else if (adv) begin
            xs[0] <= x_pre;
            ys[0] <= y_pre;
            zs[0] <= z_pre;
            ms[0] <= in_mode;
            vs[0] <= in_valid;
            for (int k = 0; k < STAGES; k++) begin
                xs[k+1] <= xn[k];
                ys[k+1] <= yn[k];
                zs[k+1] <= zn[k];
                ms[k+1] <= ms[k];
                vs[k+1] <= vs[k];
            end
        end
    end

    assign out_valid = vs[STAGES];
    assign out_mode  = ms[STAGES];
    assign x_out     = xs[STAGES];
    assign y_out     = ys[STAGES];
    assign z_out     = zs[STAGES];
endmodule

// File: doc/cordic_pipe.md
# cordic_pipe

Parametrised, fully pipelined signed CORDIC engine. It generalises the single fixed-shift rotation stage into STAGES unrolled micro-rotations with a quadrant pre-rotation stage, per-sample rotation/vectoring mode, valid/ready flow control and asynchronous reset. It sits between the sample source and the magnitude/phase or sin/cos consumers in the CORDIC datapath, and accepts one sample per clock.

## Interface
- WIDTH, 16: signed x/y input width; internal and output x/y width is WIDTH+2 (guard bits for the 1.6468 gain).
- ZWIDTH, 32: signed angle width, binary angle measure; 2^ZWIDTH represents 2π, so 0x2000_0000 = 45° at ZWIDTH=32.
- STAGES, 14: number of micro-rotation stages, legal range 1..ZWIDTH-2.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  pipeline can accept; equals adv.
- in_mode  in  1  0 = rotation (drive z→0), 1 = vectoring (drive y→0).
- x_in, y_in  in  WIDTH  signed.
- z_in  in  ZWIDTH  signed angle.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- out_mode  out  1  mode of the sample at the output.
- x_out, y_out  out  WIDTH+2  signed results, not gain-compensated.
- z_out  out  ZWIDTH  signed residual or accumulated angle.

## Operation
- Stage 0 (quadrant pre-rotation). x/y are sign-extended to WIDTH+2.
  - Rotation mode, z top two bits 01 or 10 (|angle| > 90°): negate x and y, z += 2^(ZWIDTH-1) (wraps modulo 2^ZWIDTH).
  - Vectoring mode, x < 0: negate x and y, z += 2^(ZWIDTH-1).
  - Otherwise pass through unchanged.
- Stage i+1 (i = 0..STAGES-1), with shifts arithmetic (>>>), all ops signed, two's-complement wrap:
  - x' = x − d·(y>>>i)
  - y' = y + d·(x>>>i)
  - z' = z − d·atan_i
- Direction d:
  - Rotation: d = +1 if z ≥ 0, else −1.
  - Vectoring: d = +1 if y < 0, else −1.
- atan_i = round(atan(2^-i)/(2π)·2^32) >> (32−ZWIDTH), held as a constant table. First entries: 0x2000_0000, 0x12E4_051E, 0x09FB_385B, 0x0511_11D4.
- Mode and valid travel with the data; each stage register holds x, y, z, mode and valid.
- Stage registers carrying valid=0 still shift but their data is don't-care; out_valid is masked by valid.

## Timing
- Latency: STAGES+1 accepted-and-advanced cycles from an input handshake to out_valid. Throughput is 1 sample per clock while out_ready=1.
- Flow control:
  - adv = !out_valid || out_ready.
  - All stage registers, including valid bits, load only when adv=1; when adv=0 every stage holds.
  - in_ready = adv (combinational).
  - Input is captured when in_valid && in_ready.
  - Bubbles are not compressed.
- Output stability: while out_valid=1 and out_ready=0, out_valid, out_mode, x_out, y_out and z_out hold stable.
- Reset (asynchronous, immediate):
  - All valid bits, out_valid, out_mode, x_out, y_out and z_out go to 0.
  - Reset mid-stream discards all in-flight samples; none emerge after release.
  - First acceptance is possible on the first clock edge after rst deasserts.
- Boundary cases:
  - z_in = −2^(ZWIDTH-1) (−180°) is treated as |angle| > 90°.
  - z_in = 2^(ZWIDTH-2) (exactly +90°, bits 01) is pre-rotated.
  - x_in = y_in = 0 in vectoring mode yields x=y=0 and a z that depends only on the d sequence; this is not an error.
  - Full-scale inputs must not overflow WIDTH+2.

## Test plan
All tests use WIDTH=16, ZWIDTH=32, STAGES=14, with tolerance ±4 LSB on x/y and ±2^19 on z.

- Rotation: x=10000, y=0, z=0x2000_0000, mode 0 → after 15 cycles out_valid, x≈y≈11645, z≈0.
- Vectoring: x=10000, y=10000, z=0, mode 1 → x≈23290, y≈0, z≈0x2000_0000. Also x=−10000, y=0 → x≈16468, y≈0, z≈0x8000_0000.
- Quadrant: rotation with x=10000, y=0, z=0x6000_0000 (135°) → x≈−11645, y≈11645. Also z=0x8000_0000 → x≈−16468, y≈0.
- Streaming: 100 back-to-back random samples with mixed modes and out_ready=1 → 100 results in order, each matching a bit-accurate reference model, no gaps.
- Backpressure: drop out_ready for 5 cycles mid-stream → in_ready=0 during the stall, outputs stable, no loss or duplication; order is preserved after release.
- Reset: assert rst asynchronously between clock edges with 8 samples in flight → out_valid=0 immediately; no stale outputs after release; a fresh sample returns its correct result after 15 cycles.
